pu_msp430_dbg_runctl: RTL and testbench
=======================================

PU_MSP430_DBG_RUNCTL -- requirements
Module: pu_msp430_dbg_runctl

Interface
REQ-001 SHALL have parameter NUM_HWBRK, default 4, meaning number of hardware-breakpoint units feeding this block (legal range 1..4).
REQ-002 SHALL have port dbg_clk  input  1  debug unit clock; all state is clocked on the rising edge.
REQ-003 SHALL have port dbg_rst  input  1  debug unit reset, asynchronous, active-high.
REQ-004 SHALL have ports brk_halt and brk_pnd  input  NUM_HWBRK  per-unit break command and per-unit break/watch-point pending flag.
REQ-005 SHALL have port cpu_ctl_wr  input  1  CPU_CTL write strobe.
REQ-006 SHALL have port cpu_stat_wr  input  1  CPU_STAT write strobe.
REQ-007 SHALL have port dbg_din  input  8  debug write data.
REQ-008 SHALL have ports decode_noirq, sw_brk_op and puc_pnd_set  input  1 each  meaning instruction decode, decoded software-breakpoint opcode and PUC occurred.
REQ-009 SHALL have port dbg_halt_st  input  1  CPU halted status from the frontend.
REQ-010 SHALL have ports dbg_halt_cmd, dbg_freeze and dbg_cpu_reset  output  1 each.
REQ-011 SHALL have ports cpu_ctl_dout and cpu_stat_dout  output  8 each  register read data.

Function
REQ-012 CPU_CTL SHALL have the following bits, where bits 0-2 are write-only pulses that read as 0:
- [0] HALT
- [1] RUN
- [2] ISTEP
- [3] SW_BRK_EN
- [4] FRZ_BRK_EN
- [5] RST_BRK_EN
- [6] CPU_RST
- [7] reserved, reads 0
REQ-013 CPU_STAT SHALL have the following bits:
- [0] HALT_RUN = dbg_halt_st, live
- [2] SWBRK_PND, sticky
- [3] HWBRK_PND = OR of brk_pnd, live
- [4] PUC_PND, sticky
- other bits read 0
REQ-014 Writing 1 to a sticky CPU_STAT bit SHALL clear it; a set event in the same cycle SHALL win over the clear.
REQ-015 The run-control FSM SHALL have the states RUN, HALT, STEP_REL and STEP_WAIT.
REQ-016 dbg_halt_cmd SHALL be 1 in HALT and 0 in every other state; it is a registered output.
REQ-017 halt_evt SHALL be the OR of: a write with HALT=1; any brk_halt bit; (sw_brk_op & decode_noirq & SW_BRK_EN); (puc_pnd_set & RST_BRK_EN).
REQ-018 In RUN, halt_evt SHALL cause a transition to HALT on the next edge.
REQ-019 In HALT, the following transitions SHALL apply:
- a write with RUN=1 and HALT=0 moves to RUN;
- a write with ISTEP=1, RUN=0 and HALT=0 while dbg_halt_st=1 moves to STEP_REL;
- ISTEP while dbg_halt_st=0 is ignored;
- RUN=1 and ISTEP=1 together resolve to RUN.
REQ-020 STEP_REL SHALL last exactly one cycle and then move to STEP_WAIT.
REQ-021 STEP_WAIT SHALL move to HALT on the first decode_noirq=1 or on any halt_evt.
REQ-022 halt_evt SHALL have priority over RUN or ISTEP arriving in the same cycle, in every state.
REQ-023 dbg_freeze SHALL equal FRZ_BRK_EN & dbg_halt_st, combinationally.
REQ-024 dbg_cpu_reset SHALL equal the CPU_RST register bit.
REQ-025 SWBRK_PND SHALL be set on the software-break halt_evt term.
REQ-026 PUC_PND SHALL be set on puc_pnd_set, regardless of RST_BRK_EN.
REQ-027 Register read data SHALL be combinational from register state, with no read strobe.

Reset
REQ-028 On dbg_rst, the FSM SHALL enter RUN and CPU_CTL SHALL become 8'h00.
REQ-029 On dbg_rst, SWBRK_PND and PUC_PND SHALL become 0 and dbg_halt_cmd SHALL become 0.
REQ-030 A reset asserted in STEP_REL or STEP_WAIT SHALL abort the step, with no residual halt.

Configuration
REQ-031 Software breakpoint support SHALL be controlled by the macro DBG_SWBRK_EN.
REQ-032 With DBG_SWBRK_EN defined, SW_BRK_EN, SWBRK_PND and the sw_brk_op term SHALL behave as in REQ-012 to REQ-025.
REQ-033 Without DBG_SWBRK_EN, SW_BRK_EN and SWBRK_PND SHALL read 0 and their flops are removed.
REQ-034 Without DBG_SWBRK_EN, sw_brk_op SHALL be ignored.

Structure
REQ-035 The shared package pu_msp430_dbg_pkg SHALL hold:
- the FSM state enum;
- the CPU_CTL and CPU_STAT bit-index constants;
- the CPU_CTL reset value.
REQ-036 The FSM SHALL be placed in the sub-module pu_msp430_dbg_step_fsm; register storage and read muxing SHALL stay in the top module.

Verification
REQ-037 The bench SHALL cover:
- Reset, then write CPU_CTL=8'h01 -> dbg_halt_cmd=1 one cycle later.
- CPU_STAT reads 8'h01 once dbg_halt_st=1.
- From HALT with dbg_halt_st=1, write 8'h04 -> dbg_halt_cmd is 0 for STEP_REL, stays 0 until decode_noirq, then is 1 on the next edge.
- From RUN, pulse brk_halt[2] with brk_pnd[2]=1 -> dbg_halt_cmd=1 and CPU_STAT[3]=1.
- In HALT, a RUN write in the same cycle as brk_halt[0] -> stays in HALT.
- CPU_CTL=8'h08, sw_brk_op=1, decode_noirq=1 -> HALT and SWBRK_PND=1.
- Write CPU_STAT=8'h04 -> SWBRK_PND=0; a simultaneous new event keeps it at 1.
- Without DBG_SWBRK_EN the same stimulus -> no halt and CPU_STAT[2]=0.
- CPU_CTL=8'h20 with puc_pnd_set pulsed -> HALT and PUC_PND=1.
- dbg_rst asserted during STEP_WAIT -> RUN, dbg_halt_cmd=0 and cpu_ctl_dout=8'h00.

Source files
------------

// File: rtl/pu_msp430_dbg_pkg.sv
// Shared definitions for the MSP430 debug run-control block: FSM states,
// CPU_CTL / CPU_STAT bit positions and the CPU_CTL reset value.
package pu_msp430_dbg_pkg;

  localparam int unsigned DBG_DW = 8;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT      = 2'd1,
    ST_STEP_REL  = 2'd2,
    ST_STEP_WAIT = 2'd3
  } dbg_state_e;

  localparam int unsigned CTL_HALT       = 0;
  localparam int unsigned CTL_RUN        = 1;
  localparam int unsigned CTL_ISTEP      = 2;
  localparam int unsigned CTL_SW_BRK_EN  = 3;
  localparam int unsigned CTL_FRZ_BRK_EN = 4;
  localparam int unsigned CTL_RST_BRK_EN = 5;
  localparam int unsigned CTL_CPU_RST    = 6;

  localparam int unsigned STAT_HALT_RUN  = 0;
  localparam int unsigned STAT_SWBRK_PND = 2;
  localparam int unsigned STAT_HWBRK_PND = 3;
  localparam int unsigned STAT_PUC_PND   = 4;

  localparam logic [DBG_DW-1:0] CPU_CTL_RST = 8'h00;

endpackage

// File: rtl/pu_msp430_dbg_step_fsm.sv
// Run / halt / single-step control FSM; dbg_halt_cmd is registered and is 1
// exactly while the FSM sits in HALT.
import pu_msp430_dbg_pkg::*;

module pu_msp430_dbg_step_fsm (
  input  logic dbg_clk,
  input  logic dbg_rst,
  input  logic halt_evt,
  input  logic run_cmd,
  input  logic istep_cmd,
  input  logic decode_noirq,
  input  logic dbg_halt_st,
  output logic dbg_halt_cmd
);

  dbg_state_e state;

  // halt_evt wins over RUN/ISTEP in every state
  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      state        <= ST_RUN;
      dbg_halt_cmd <= 1'b0;
    end else if (halt_evt) begin
      state        <= ST_HALT;
      dbg_halt_cmd <= 1'b1;
    end else begin
      case (state)
        ST_HALT: begin
          if (run_cmd) begin
            state        <= ST_RUN;
            dbg_halt_cmd <= 1'b0;
          end else if (istep_cmd && dbg_halt_st) begin
            state        <= ST_STEP_REL;
            dbg_halt_cmd <= 1'b0;
          end
        end
        ST_STEP_REL: begin
          state <= ST_STEP_WAIT;
        end
        ST_STEP_WAIT: begin
          if (decode_noirq) begin
            state        <= ST_HALT;
            dbg_halt_cmd <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: rtl/pu_msp430_dbg_runctl.sv
// Debug run-control: CPU_CTL/CPU_STAT registers, halt-event combining and the
// step FSM. Define DBG_SWBRK_EN to build in software-breakpoint support.
import pu_msp430_dbg_pkg::*;

module pu_msp430_dbg_runctl #(
  parameter int unsigned NUM_HWBRK = 4
) (
  input  logic                  dbg_clk,
  input  logic                  dbg_rst,
  input  logic [NUM_HWBRK-1:0]  brk_halt,
  input  logic [NUM_HWBRK-1:0]  brk_pnd,
  input  logic                  cpu_ctl_wr,
  input  logic                  cpu_stat_wr,
  input  logic [DBG_DW-1:0]     dbg_din,
  input  logic                  decode_noirq,
  input  logic                  sw_brk_op,
  input  logic                  puc_pnd_set,
  input  logic                  dbg_halt_st,
  output logic                  dbg_halt_cmd,
  output logic                  dbg_freeze,
  output logic                  dbg_cpu_reset,
  output logic [DBG_DW-1:0]     cpu_ctl_dout,
  output logic [DBG_DW-1:0]     cpu_stat_dout
);

  logic frz_brk_en, rst_brk_en, cpu_rst;
  logic sw_brk_en, swbrk_pnd, puc_pnd;
  logic sw_evt, halt_evt, run_cmd, istep_cmd;
  logic unused_bits;

  // CPU_CTL persistent bits; HALT/RUN/ISTEP are pulses and never stored
  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      frz_brk_en <= CPU_CTL_RST[CTL_FRZ_BRK_EN];
      rst_brk_en <= CPU_CTL_RST[CTL_RST_BRK_EN];
      cpu_rst    <= CPU_CTL_RST[CTL_CPU_RST];
    end else if (cpu_ctl_wr) begin
      frz_brk_en <= dbg_din[CTL_FRZ_BRK_EN];
      rst_brk_en <= dbg_din[CTL_RST_BRK_EN];
      cpu_rst    <= dbg_din[CTL_CPU_RST];
    end
  end

`ifdef DBG_SWBRK_EN
  assign sw_evt = sw_brk_op & decode_noirq & sw_brk_en;

  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      sw_brk_en <= CPU_CTL_RST[CTL_SW_BRK_EN];
      swbrk_pnd <= 1'b0;
    end else begin
      if (cpu_ctl_wr) begin
        sw_brk_en <= dbg_din[CTL_SW_BRK_EN];
      end
      if (sw_evt) begin
        swbrk_pnd <= 1'b1;
      end else if (cpu_stat_wr && dbg_din[STAT_SWBRK_PND]) begin
        swbrk_pnd <= 1'b0;
      end
    end
  end

  assign unused_bits = dbg_din[7];
`else
  assign sw_evt      = 1'b0;
  assign sw_brk_en   = 1'b0;
  assign swbrk_pnd   = 1'b0;
  assign unused_bits = ^{dbg_din[7], dbg_din[CTL_SW_BRK_EN], sw_brk_op};
`endif

  // Sticky PUC pending; a set in the same cycle as a clear wins
  always_ff @(posedge dbg_clk or posedge dbg_rst) begin
    if (dbg_rst) begin
      puc_pnd <= 1'b0;
    end else if (puc_pnd_set) begin
      puc_pnd <= 1'b1;
    end else if (cpu_stat_wr && dbg_din[STAT_PUC_PND]) begin
      puc_pnd <= 1'b0;
    end
  end

  assign halt_evt  = (cpu_ctl_wr & dbg_din[CTL_HALT]) | (|brk_halt) | sw_evt |
                     (puc_pnd_set & rst_brk_en);
  assign run_cmd   = cpu_ctl_wr & dbg_din[CTL_RUN] & ~dbg_din[CTL_HALT];
  assign istep_cmd = cpu_ctl_wr & dbg_din[CTL_ISTEP] & ~dbg_din[CTL_RUN] &
                     ~dbg_din[CTL_HALT];

  pu_msp430_dbg_step_fsm u_step_fsm (
    .dbg_clk      (dbg_clk),
    .dbg_rst      (dbg_rst),
    .halt_evt     (halt_evt),
    .run_cmd      (run_cmd),
    .istep_cmd    (istep_cmd),
    .decode_noirq (decode_noirq),
    .dbg_halt_st  (dbg_halt_st),
    .dbg_halt_cmd (dbg_halt_cmd)
  );

  assign dbg_freeze    = frz_brk_en & dbg_halt_st;
  assign dbg_cpu_reset = cpu_rst;

  always_comb begin
    cpu_ctl_dout                 = '0;
    cpu_ctl_dout[CTL_SW_BRK_EN]  = sw_brk_en;
    cpu_ctl_dout[CTL_FRZ_BRK_EN] = frz_brk_en;
    cpu_ctl_dout[CTL_RST_BRK_EN] = rst_brk_en;
    cpu_ctl_dout[CTL_CPU_RST]    = cpu_rst;

    cpu_stat_dout                 = '0;
    cpu_stat_dout[STAT_HALT_RUN]  = dbg_halt_st;
    cpu_stat_dout[STAT_SWBRK_PND] = swbrk_pnd;
    cpu_stat_dout[STAT_HWBRK_PND] = |brk_pnd;
    cpu_stat_dout[STAT_PUC_PND]   = puc_pnd;
  end

endmodule

// File: tb/tb_pu_msp430_dbg_runctl.sv
// Directed bench for pu_msp430_dbg_runctl with a cycle model checked on every
// falling edge plus literal expectations; honours DBG_SWBRK_EN like the RTL.
module tb_pu_msp430_dbg_runctl;

  localparam int unsigned NB = 4;
`ifdef DBG_SWBRK_EN
  localparam bit SW = 1'b1;
`else
  localparam bit SW = 1'b0;
`endif

  logic          dbg_clk = 1'b0;
  logic          dbg_rst = 1'b1;
  logic [NB-1:0] brk_halt = '0;
  logic [NB-1:0] brk_pnd = '0;
  logic          cpu_ctl_wr = 1'b0;
  logic          cpu_stat_wr = 1'b0;
  logic [7:0]    dbg_din = '0;
  logic          decode_noirq = 1'b0;
  logic          sw_brk_op = 1'b0;
  logic          puc_pnd_set = 1'b0;
  logic          dbg_halt_st = 1'b0;
  logic          dbg_halt_cmd, dbg_freeze, dbg_cpu_reset;
  logic [7:0]    cpu_ctl_dout, cpu_stat_dout;

  int checks = 0;
  int errors = 0;

  pu_msp430_dbg_runctl #(.NUM_HWBRK(NB)) dut (
    .dbg_clk       (dbg_clk),
    .dbg_rst       (dbg_rst),
    .brk_halt      (brk_halt),
    .brk_pnd       (brk_pnd),
    .cpu_ctl_wr    (cpu_ctl_wr),
    .cpu_stat_wr   (cpu_stat_wr),
    .dbg_din       (dbg_din),
    .decode_noirq  (decode_noirq),
    .sw_brk_op     (sw_brk_op),
    .puc_pnd_set   (puc_pnd_set),
    .dbg_halt_st   (dbg_halt_st),
    .dbg_halt_cmd  (dbg_halt_cmd),
    .dbg_freeze    (dbg_freeze),
    .dbg_cpu_reset (dbg_cpu_reset),
    .cpu_ctl_dout  (cpu_ctl_dout),
    .cpu_stat_dout (cpu_stat_dout)
  );

  always #5 dbg_clk = ~dbg_clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "halted" flag plus a step in flight with a release-cycle marker
  bit       m_halted   = 1'b0;
  bit       m_stepping = 1'b0;
  bit       m_release  = 1'b0;
  bit [7:0] m_ctl      = 8'h00;
  bit       m_swp      = 1'b0;
  bit       m_puc      = 1'b0;

  always @(posedge dbg_clk or posedge dbg_rst) begin
    bit evt, run, step, sw_hit;
    if (dbg_rst) begin
      m_halted = 1'b0; m_stepping = 1'b0; m_release = 1'b0;
      m_ctl = 8'h00; m_swp = 1'b0; m_puc = 1'b0;
    end else begin
      sw_hit = SW && sw_brk_op && decode_noirq && m_ctl[3];
      evt  = (cpu_ctl_wr && dbg_din[0]) || (brk_halt != '0) || sw_hit ||
             (puc_pnd_set && m_ctl[5]);
      run  = cpu_ctl_wr && dbg_din[1] && !dbg_din[0];
      step = cpu_ctl_wr && dbg_din[2] && !dbg_din[1] && !dbg_din[0];
      if (evt) begin
        m_halted = 1'b1; m_stepping = 1'b0; m_release = 1'b0;
      end else if (m_halted) begin
        if (run) m_halted = 1'b0;
        else if (step && dbg_halt_st) begin
          m_halted = 1'b0; m_stepping = 1'b1; m_release = 1'b1;
        end
      end else if (m_stepping) begin
        if (m_release) m_release = 1'b0;
        else if (decode_noirq) begin m_halted = 1'b1; m_stepping = 1'b0; end
      end
      if (cpu_ctl_wr) m_ctl = dbg_din & (SW ? 8'h78 : 8'h70);
      if (sw_hit) m_swp = 1'b1;
      else if (cpu_stat_wr && dbg_din[2]) m_swp = 1'b0;
      if (puc_pnd_set) m_puc = 1'b1;
      else if (cpu_stat_wr && dbg_din[4]) m_puc = 1'b0;
    end
  end

  always @(negedge dbg_clk) begin
    chk("model_halt_cmd", {7'b0, dbg_halt_cmd}, {7'b0, m_halted});
    chk("model_ctl", cpu_ctl_dout, m_ctl);
    chk("model_stat", cpu_stat_dout,
        {3'b000, m_puc, |brk_pnd, m_swp, 1'b0, dbg_halt_st});
    chk("model_freeze", {7'b0, dbg_freeze}, {7'b0, m_ctl[4] & dbg_halt_st});
    chk("model_cpu_reset", {7'b0, dbg_cpu_reset}, {7'b0, m_ctl[6]});
  end

  // Advance one edge, land 1 time unit after it, then drop single-cycle strobes
  task automatic tick();
    @(posedge dbg_clk);
    #1;
    cpu_ctl_wr = 1'b0; cpu_stat_wr = 1'b0; brk_halt = '0;
    decode_noirq = 1'b0; sw_brk_op = 1'b0; puc_pnd_set = 1'b0;
  endtask

  task automatic wr_ctl(input logic [7:0] d);
    cpu_ctl_wr = 1'b1; dbg_din = d;
  endtask

  task automatic wr_stat(input logic [7:0] d);
    cpu_stat_wr = 1'b1; dbg_din = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_halt_cmd", {7'b0, dbg_halt_cmd}, 8'h00);
    chk("rst_ctl", cpu_ctl_dout, 8'h00);
    chk("rst_stat", cpu_stat_dout, 8'h00);
    dbg_rst = 1'b0;
    tick();

    wr_ctl(8'h01); tick();
    chk("halt_write", {7'b0, dbg_halt_cmd}, 8'h01);
    dbg_halt_st = 1'b1; #1;
    chk("stat_halted", cpu_stat_dout, 8'h01);

    // single step: one release cycle, wait, halt after decode
    wr_ctl(8'h04); tick();
    chk("step_rel", {7'b0, dbg_halt_cmd}, 8'h00);
    tick();
    chk("step_wait1", {7'b0, dbg_halt_cmd}, 8'h00);
    tick();
    chk("step_wait2", {7'b0, dbg_halt_cmd}, 8'h00);
    decode_noirq = 1'b1; tick();
    chk("step_done", {7'b0, dbg_halt_cmd}, 8'h01);

    wr_ctl(8'h02); tick();
    chk("run_write", {7'b0, dbg_halt_cmd}, 8'h00);
    brk_halt = 4'b0100; brk_pnd = 4'b0100; tick();
    chk("hwbrk_halt", {7'b0, dbg_halt_cmd}, 8'h01);
    chk("hwbrk_stat", cpu_stat_dout, 8'h09);
    brk_pnd = '0;

    // RUN and a breakpoint in the same cycle: breakpoint wins
    wr_ctl(8'h02); brk_halt = 4'b0001; tick();
    chk("run_vs_brk", {7'b0, dbg_halt_cmd}, 8'h01);
    wr_ctl(8'h02); tick();
    chk("run_again", {7'b0, dbg_halt_cmd}, 8'h00);

    wr_ctl(8'h08); tick();
    chk("ctl_swen", cpu_ctl_dout, SW ? 8'h08 : 8'h00);
    sw_brk_op = 1'b1; decode_noirq = 1'b1; tick();
    chk("swbrk_halt", {7'b0, dbg_halt_cmd}, SW ? 8'h01 : 8'h00);
    chk("swbrk_pnd", {7'b0, cpu_stat_dout[2]}, SW ? 8'h01 : 8'h00);
    wr_stat(8'h04); tick();
    chk("swbrk_clr", {7'b0, cpu_stat_dout[2]}, 8'h00);
    wr_stat(8'h04); sw_brk_op = 1'b1; decode_noirq = 1'b1; tick();
    chk("swbrk_set_wins", {7'b0, cpu_stat_dout[2]}, SW ? 8'h01 : 8'h00);
    wr_stat(8'h04); tick();

    wr_ctl(8'h22); tick();
    chk("rstbrk_run", {7'b0, dbg_halt_cmd}, 8'h00);
    chk("ctl_rstbrk", cpu_ctl_dout, 8'h20);
    puc_pnd_set = 1'b1; tick();
    chk("puc_halt", {7'b0, dbg_halt_cmd}, 8'h01);
    chk("puc_pnd", {7'b0, cpu_stat_dout[4]}, 8'h01);
    wr_stat(8'h10); tick();
    chk("puc_clr", {7'b0, cpu_stat_dout[4]}, 8'h00);

    wr_ctl(8'h50); tick();
    chk("freeze", {7'b0, dbg_freeze}, 8'h01);
    chk("cpu_reset", {7'b0, dbg_cpu_reset}, 8'h01);
    dbg_halt_st = 1'b0; #1;
    chk("freeze_run", {7'b0, dbg_freeze}, 8'h00);
    // ISTEP ignored while the CPU is not yet halted
    wr_ctl(8'h04); tick();
    chk("istep_ignored", {7'b0, dbg_halt_cmd}, 8'h01);
    dbg_halt_st = 1'b1;

    // reset in STEP_WAIT aborts the step
    wr_ctl(8'h04); tick(); tick();
    chk("pre_rst_wait", {7'b0, dbg_halt_cmd}, 8'h00);
    dbg_rst = 1'b1; #1;
    chk("rst_step_halt", {7'b0, dbg_halt_cmd}, 8'h00);
    chk("rst_step_ctl", cpu_ctl_dout, 8'h00);
    tick();
    dbg_rst = 1'b0;
    decode_noirq = 1'b1; tick();
    chk("no_residual", {7'b0, dbg_halt_cmd}, 8'h00);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
